fc_debug_stream_arbiter: RTL

FC_DEBUG_STREAM_ARBITER -- requirements
Module: fc_debug_stream_arbiter

---
 rtl/fc_debug_stream_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/fc_debug_stream_arbiter.sv
// Debug stream arbiter: merges NUM_IN Avalon-ST requester ports onto one
// output stream with packet-level round-robin locking. Beats that arrive
// outside a packet while no port owns the output are accepted, dropped and
// counted in orphan_count.
module fc_debug_stream_arbiter #(
    parameter int NUM_IN = 2,
    parameter int DATA_W = 256
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_IN*DATA_W-1:0] st_in_data,
    input  logic [NUM_IN-1:0]        st_in_valid,
    input  logic [NUM_IN-1:0]        st_in_startofpacket,
    input  logic [NUM_IN-1:0]        st_in_endofpacket,
    input  logic [NUM_IN*5-1:0]      st_in_empty,
    output logic [NUM_IN-1:0]        st_in_ready,
    output logic [DATA_W-1:0]        st_out_data,
    output logic [4:0]               st_out_empty,
    output logic                     st_out_valid,
    output logic                     st_out_startofpacket,
    output logic                     st_out_endofpacket,
    output logic [1:0]               st_out_channel,
    input  logic                     st_out_ready,
    output logic [15:0]              orphan_count
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t            state_q, state_d;
    logic [1:0]        grant_q;
    logic [1:0]        last_grant_q;
    logic [1:0]        pick;
    logic              found;
    logic [2:0]        cand;

    // Per-port qualifiers widened to the 4-port maximum so a 2-bit index is always in range.
    logic [3:0]        valid_pad, sop_pad, eop_pad, req_pad, ready_pad, orphan_pad;
    logic [2:0]        orphan_cnt;
    logic              accept, accept_eop;
    logic [DATA_W-1:0] sel_data;
    logic [4:0]        sel_empty;

    // Output register stage
    logic [DATA_W-1:0] out_data_p1;
    logic [4:0]        out_empty_p1;
    logic              out_sop_p1, out_eop_p1;
    logic [1:0]        out_chan_p1;
    logic              vld_p1;
    logic [15:0]       orphan_q;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [2:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {14'd0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    assign valid_pad  = 4'(st_in_valid);
    assign sop_pad    = 4'(st_in_startofpacket);
    assign eop_pad    = 4'(st_in_endofpacket);
    assign req_pad    = valid_pad & sop_pad;
    assign orphan_pad = valid_pad & ~sop_pad;

    assign sel_data  = st_in_data[int'(grant_q)*DATA_W +: DATA_W];
    assign sel_empty = st_in_empty[int'(grant_q)*5 +: 5];

    // Round-robin search over start-of-packet requests, beginning after last_grant.
    always_comb begin
        found = 1'b0;
        pick  = last_grant_q;
        cand  = '0;
        for (int k = 1; k <= NUM_IN; k++) begin
            cand = {1'b0, last_grant_q} + 3'(k);
            if (cand >= 3'(NUM_IN)) cand = cand - 3'(NUM_IN);
            if (!found && req_pad[cand[1:0]]) begin
                found = 1'b1;
                pick  = cand[1:0];
            end
        end
    end

    // Ready generation: orphan drain while idle, locked port gated by output-register space.
    always_comb begin
        ready_pad = '0;
        if (reset_n) begin
            if (state_q == IDLE) ready_pad = orphan_pad;
            else ready_pad[grant_q] = !vld_p1 || st_out_ready;
        end
    end

    assign st_in_ready = ready_pad[NUM_IN-1:0];
    assign accept      = (state_q == LOCKED) && valid_pad[grant_q] && ready_pad[grant_q];
    assign accept_eop  = accept && eop_pad[grant_q];
    assign orphan_cnt  = (state_q == IDLE) ?
                         3'((valid_pad[0] & ready_pad[0])) + 3'((valid_pad[1] & ready_pad[1])) +
                         3'((valid_pad[2] & ready_pad[2])) + 3'((valid_pad[3] & ready_pad[3])) : 3'd0;

    // Next-state logic: lock on a granted sop, release only on an accepted eop.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (found) state_d = LOCKED;
            LOCKED:  if (accept_eop) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM state, current grant and round-robin pointer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= 2'(NUM_IN - 1);
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && found) grant_q <= pick;
            if (accept_eop) last_grant_q <= grant_q;
        end
    end

    // Output register: load on accept, drain on downstream ready, hold otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_data_p1  <= '0;
            out_empty_p1 <= '0;
            out_sop_p1   <= 1'b0;
            out_eop_p1   <= 1'b0;
            out_chan_p1  <= '0;
            vld_p1       <= 1'b0;
        end else if (accept) begin
            out_data_p1  <= sel_data;
            out_empty_p1 <= sel_empty;
            out_sop_p1   <= sop_pad[grant_q];
            out_eop_p1   <= eop_pad[grant_q];
            out_chan_p1  <= grant_q;
            vld_p1       <= 1'b1;
        end else if (vld_p1 && st_out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    // Saturating count of beats dropped outside a packet.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) orphan_q <= '0;
        else          orphan_q <= sat_add16(orphan_q, orphan_cnt);
    end

    assign st_out_data          = out_data_p1;
    assign st_out_empty         = out_empty_p1;
    assign st_out_startofpacket = out_sop_p1;
    assign st_out_endofpacket   = out_eop_p1;
    assign st_out_channel       = out_chan_p1;
    assign st_out_valid         = vld_p1;
    assign orphan_count         = orphan_q;

endmodule
